// File: rtl/sap_sequencer.sv
// sap_sequencer: controller/sequencer for the 8-bit bus computer.
// A one-hot T-state ring steps fetch (T1-T3) and execute (T4-T6).
// The control word is decoded combinationally from the ring state and the opcode.
// HLT is sticky and is cleared only by RESET.
// Optional feature: define SEQ_EARLY_END_EN so that each instruction returns to T1
// right after its last T-state that carries strobes.
module sap_sequencer #(
  parameter int NT  = 6,  // ring length; the decode below assumes exactly 6
  parameter int OPW = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  output logic [NT-1:0]  t_state,
  output logic           inc_PC,
  output logic           OE_PC,
  output logic           WE_MAR,
  output logic           OE_RAM,
  output logic           WE_IR,
  output logic           OE_IR,
  output logic           WE_Acc,
  output logic           OE_Acc,
  output logic           WE_Breg,
  output logic           SUB,
  output logic           OE_ALU,
  output logic           WE_OR,
  output logic           HLT
);

  // Ring encodings: all-zero is idle/halted, bit0 is T1.
  typedef enum logic [NT-1:0] {
    S_IDLE = 6'b000000,
    S_T1   = 6'b000001,
    S_T2   = 6'b000010,
    S_T3   = 6'b000100,
    S_T4   = 6'b001000,
    S_T5   = 6'b010000,
    S_T6   = 6'b100000
  } state_t;

  localparam logic [OPW-1:0] OP_LDA = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4'hE);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

`ifdef SEQ_EARLY_END_EN
  localparam logic EARLY_END = 1'b1;
`else
  localparam logic EARLY_END = 1'b0;
`endif

  state_t state_reg, state_next;
  logic   hlt_reg, hlt_next;
  logic   is_alu_op;
  logic   is_lda;

  assign is_lda    = (opcode == OP_LDA);
  assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_SUB);

  // State register: ring position and sticky halt flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= S_IDLE;
      hlt_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      hlt_reg   <= hlt_next;
    end
  end

  // Next-state logic. The ring is frozen when run=0, and it stays frozen for good once halted.
  always_comb begin
    state_next = state_reg;
    hlt_next   = hlt_reg;
    if (run && !hlt_reg) begin
      unique case (state_reg)
        S_IDLE: state_next = S_T1;
        S_T1:   state_next = S_T2;
        S_T2:   state_next = S_T3;
        S_T3:   state_next = S_T4;
        S_T4: begin
          if (opcode == OP_HLT) begin
            state_next = S_IDLE;
            hlt_next   = 1'b1;
          end else if (EARLY_END && !is_lda && !is_alu_op) begin
            // OUT and NOP carry no strobes after T4.
            state_next = S_T1;
          end else begin
            state_next = S_T5;
          end
        end
        S_T5:   state_next = (EARLY_END && is_lda) ? S_T1 : S_T6;
        S_T6:   state_next = S_T1;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Control word decode. Everything is forced low while frozen or halted, and at most one OE_* is high.
  always_comb begin
    inc_PC  = 1'b0;
    OE_PC   = 1'b0;
    WE_MAR  = 1'b0;
    OE_RAM  = 1'b0;
    WE_IR   = 1'b0;
    OE_IR   = 1'b0;
    WE_Acc  = 1'b0;
    OE_Acc  = 1'b0;
    WE_Breg = 1'b0;
    SUB     = 1'b0;
    OE_ALU  = 1'b0;
    WE_OR   = 1'b0;
    if (run && !hlt_reg) begin
      unique case (state_reg)
        S_T1: begin
          OE_PC  = 1'b1;
          WE_MAR = 1'b1;
        end
        S_T2: inc_PC = 1'b1;
        S_T3: begin
          OE_RAM = 1'b1;
          WE_IR  = 1'b1;
        end
        S_T4: begin
          if (is_lda || is_alu_op) begin
            OE_IR  = 1'b1;
            WE_MAR = 1'b1;
          end else if (opcode == OP_OUT) begin
            OE_Acc = 1'b1;
            WE_OR  = 1'b1;
          end
        end
        S_T5: begin
          if (is_lda) begin
            OE_RAM = 1'b1;
            WE_Acc = 1'b1;
          end else if (is_alu_op) begin
            OE_RAM  = 1'b1;
            WE_Breg = 1'b1;
            // SUB is asserted a T-state early so that the ALU has settled before the T6 capture.
            SUB     = (opcode == OP_SUB);
          end
        end
        S_T6: begin
          if (is_alu_op) begin
            OE_ALU = 1'b1;
            WE_Acc = 1'b1;
            SUB    = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign t_state = state_reg;
  assign HLT     = hlt_reg;

endmodule

// File: tb/tb_sap_sequencer.sv
// tb_sap_sequencer: scoreboard bench for sap_sequencer.
// A T-state model produces the expected outputs for each cycle and pushes them to a queue.
// The DUT outputs are compared against the popped entry on the falling edge.
module tb_sap_sequencer;

  logic       CLK, RESET, run;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic inc_PC, OE_PC, WE_MAR, OE_RAM, WE_IR, OE_IR;
  logic WE_Acc, OE_Acc, WE_Breg, SUB, OE_ALU, WE_OR, HLT;

  sap_sequencer #(.NT(6), .OPW(4)) dut (
    .CLK(CLK), .RESET(RESET), .run(run), .opcode(opcode), .t_state(t_state),
    .inc_PC(inc_PC), .OE_PC(OE_PC), .WE_MAR(WE_MAR), .OE_RAM(OE_RAM),
    .WE_IR(WE_IR), .OE_IR(OE_IR), .WE_Acc(WE_Acc), .OE_Acc(OE_Acc),
    .WE_Breg(WE_Breg), .SUB(SUB), .OE_ALU(OE_ALU), .WE_OR(WE_OR), .HLT(HLT)
  );

  // 10-time-unit clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [5:0]  ts;
    logic        hlt;
    logic [11:0] ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tm       = 0;    // model T-step: 0 = idle, 1..6 = T1..T6
  bit   hm       = 1'b0; // model halt flag

  // Positions of the strobes within the packed control word
  localparam int B_INC = 11, B_OEPC = 10, B_WMAR = 9, B_OERAM = 8, B_WIR = 7, B_OEIR = 6;
  localparam int B_WACC = 5, B_OEACC = 4, B_WB = 3, B_SUB = 2, B_OEALU = 1, B_WOR = 0;

  function automatic logic [11:0] obs_ctrl();
    return {inc_PC, OE_PC, WE_MAR, OE_RAM, WE_IR, OE_IR,
            WE_Acc, OE_Acc, WE_Breg, SUB, OE_ALU, WE_OR};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [11:0] exp_ctrl(input int s, input logic [3:0] op, input logic r, input bit h);
    logic [11:0] c;
    c = '0;
    if (r && !h) begin
      case (s)
        1: begin c[B_OEPC] = 1'b1; c[B_WMAR] = 1'b1; end
        2: c[B_INC] = 1'b1;
        3: begin c[B_OERAM] = 1'b1; c[B_WIR] = 1'b1; end
        4: begin
          if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin c[B_OEIR] = 1'b1; c[B_WMAR] = 1'b1; end
          if (op == 4'hE) begin c[B_OEACC] = 1'b1; c[B_WOR] = 1'b1; end
        end
        5: begin
          if (op == 4'h0) begin c[B_OERAM] = 1'b1; c[B_WACC] = 1'b1; end
          if (op == 4'h1) begin c[B_OERAM] = 1'b1; c[B_WB] = 1'b1; end
          if (op == 4'h2) begin c[B_OERAM] = 1'b1; c[B_WB] = 1'b1; c[B_SUB] = 1'b1; end
        end
        6: begin
          if (op == 4'h1) begin c[B_OEALU] = 1'b1; c[B_WACC] = 1'b1; end
          if (op == 4'h2) begin c[B_OEALU] = 1'b1; c[B_WACC] = 1'b1; c[B_SUB] = 1'b1; end
        end
        default: ;
      endcase
    end
    return c;
  endfunction

  // Last T-step of an instruction (the ring wraps to T1 after it)
  function automatic int last_step(input logic [3:0] op);
`ifdef SEQ_EARLY_END_EN
    if (op == 4'h0) return 5;
    if (op == 4'h1 || op == 4'h2) return 6;
    return 4;
`else
    return 6;
`endif
  endfunction

  // One cycle: drive inputs, push the expectation, compare on negedge, advance the model on posedge
  task automatic step(input logic r, input logic [3:0] op);
    exp_t e, got;
    logic [4:0] oe;
    run    = r;
    opcode = (tm >= 1 && tm <= 3) ? 4'($urandom) : op;
    e.ts   = (tm == 0) ? 6'd0 : 6'(1 << (tm - 1));
    e.hlt  = hm;
    e.ctrl = exp_ctrl(tm, opcode, r, hm);
    exp_q.push_back(e);
    @(negedge CLK);
    got = exp_q.pop_front();
    check_eq("t_state", 32'(t_state), 32'(got.ts));
    check_eq("HLT", 32'(HLT), 32'(got.hlt));
    check_eq("ctrl", 32'(obs_ctrl()), 32'(got.ctrl));
    oe = {OE_PC, OE_RAM, OE_IR, OE_Acc, OE_ALU};
    check_eq("oe_onehot", 32'($countones(oe) <= 1), 32'd1);
    $display("step run=%0b op=%h t_state=%b HLT=%0b ctrl=%b", r, opcode, t_state, HLT, obs_ctrl());
    @(posedge CLK);
    if (!hm && r) begin
      if (tm == 0) tm = 1;
      else if (tm == 4 && opcode == 4'hF) begin tm = 0; hm = 1'b1; end
      else if (tm == last_step(opcode)) tm = 1;
      else tm = tm + 1;
    end
    #1;
  endtask

  // Run one instruction from T1 until the ring wraps (or halts), optionally freezing for 3 cycles at pause_at
  task automatic do_instr(input logic [3:0] op, input int pause_at);
    int n;
    bit paused;
    n = 0;
    paused = 1'b0;
    if (tm == 0) step(1'b1, op);
    do begin
      if (tm == pause_at && !paused) begin
        repeat (3) step(1'b0, op);
        paused = 1'b1;
      end
      step(1'b1, op);
      n++;
    end while (tm != 1 && tm != 0 && n < 8);
    $display("instr op=%h done in %0d steps", op, n);
  endtask

  // Asynchronous reset pulse placed between clock edges; the outputs must clear immediately
  task automatic pulse_reset();
    #2 RESET = 1'b1;
    #1;
    check_eq("rst_t_state", 32'(t_state), 32'd0);
    check_eq("rst_HLT", 32'(HLT), 32'd0);
    check_eq("rst_ctrl", 32'(obs_ctrl()), 32'd0);
    $display("async reset: t_state=%b HLT=%0b ctrl=%b", t_state, HLT, obs_ctrl());
    RESET = 1'b0;
    tm = 0;
    hm = 1'b0;
  endtask

  initial begin
    int n;
    RESET  = 1'b1;
    run    = 1'b0;
    opcode = 4'h0;
    #2;
    check_eq("reset_t_state", 32'(t_state), 32'd0);
    check_eq("reset_HLT", 32'(HLT), 32'd0);
    check_eq("reset_ctrl", 32'(obs_ctrl()), 32'd0);
    #10 RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Idle with run=0, then start the first fetch
    repeat (5) step(1'b0, 4'h0);
    do_instr(4'h0, 0);       // LDA
    do_instr(4'h1, 5);       // ADD, frozen mid-T5
    do_instr(4'h2, 0);       // SUB
    do_instr(4'hE, 0);       // OUT
    do_instr(4'h7, 0);       // NOP
    do_instr(4'h2, 6);       // SUB, frozen in T6
    do_instr(4'hF, 0);       // HLT
    for (int i = 0; i < 10; i++) step(1'(i % 2), 4'($urandom));
    pulse_reset();

    // ADD interrupted by an asynchronous reset during T5, then a fresh start
    n = 0;
    if (tm == 0) step(1'b1, 4'h1);
    while (tm != 5 && n < 8) begin
      step(1'b1, 4'h1);
      n++;
    end
    pulse_reset();
    do_instr(4'h0, 0);
    do_instr(4'hE, 0);
    do_instr(4'h1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
